// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: registered sync/DE flags aligned with o_x/o_y.
// Optional frame counter output o_frame_cnt is built only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int X_W      = 11,
  parameter int Y_W      = 10
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_pix_stb,
  input  logic           i_en,
  output logic           o_hs,
  output logic           o_vs,
  output logic           o_de,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_line_end,
  output logic           o_frame_end,
  output logic           o_active_end
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]    o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_LAST = Y_W'(V_ACTIVE - 1);

  // Interval bounds kept 32 bits wide so a sync that ends exactly at H_TOTAL cannot overflow X_W.
  localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
  localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
  localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  logic           adv;
  logic           h_last;
  logic           v_last;
  logic [X_W-1:0] h_nxt;
  logic [Y_W-1:0] v_nxt;
  logic [31:0]    h_nxt_w;
  logic [31:0]    v_nxt_w;
  logic           de_nxt;
  logic           hs_nxt;
  logic           vs_nxt;

  assign adv    = i_pix_stb & i_en & ~i_rst;
  assign h_last = (o_x == H_LAST);
  assign v_last = (o_y == V_LAST);

  always_comb begin
    h_nxt = o_x + X_W'(1);
    v_nxt = o_y;
    if (h_last) begin
      h_nxt = '0;
      v_nxt = v_last ? '0 : o_y + Y_W'(1);
    end
  end

  // Flags are decoded from the next coordinates so they land on the same edge as o_x/o_y.
  assign h_nxt_w = 32'(h_nxt);
  assign v_nxt_w = 32'(v_nxt);
  assign de_nxt  = (h_nxt_w < H_ACT_END) && (v_nxt_w < V_ACT_END);
  assign hs_nxt  = (h_nxt_w >= HS_START) && (h_nxt_w < HS_END);
  assign vs_nxt  = (v_nxt_w >= VS_START) && (v_nxt_w < VS_END);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_x  <= '0;
      o_y  <= '0;
      o_de <= 1'b1;
      o_hs <= ~HS_ON;
      o_vs <= ~VS_ON;
    end else if (adv) begin
      o_x  <= h_nxt;
      o_y  <= v_nxt;
      o_de <= de_nxt;
      o_hs <= hs_nxt ? HS_ON : ~HS_ON;
      o_vs <= vs_nxt ? VS_ON : ~VS_ON;
    end
  end

  assign o_line_end   = adv & h_last;
  assign o_frame_end  = o_line_end & v_last;
  assign o_active_end = adv & (o_x == H_ACT_LAST) & (o_y == V_ACT_LAST);

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
    end else if (o_frame_end) begin
      o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end
`endif

endmodule
